// File: rtl/axi_stream_remove_header.sv
// axi_stream_remove_header
// Strips a per-packet count of leading bytes from a byte-oriented stream and
// realigns the remaining bytes into full, left-justified output beats.
// Byte 0 of a beat is the most significant byte; keep bits are left-justified.

module axi_stream_remove_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,

    input  logic                    valid_remove,
    input  logic [BYTE_CNT_WD:0]    byte_remove_cnt,
    output logic                    ready_remove,

    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out
);

    // Byte counts 0..DATA_BYTE_WD fit CNT_W bits; residual plus a beat
    // (0..2*DATA_BYTE_WD) needs one more bit.
    localparam int CNT_W = BYTE_CNT_WD + 1;
    localparam int TOT_W = BYTE_CNT_WD + 2;

    localparam logic [CNT_W-1:0] BEAT_BYTES   = CNT_W'(DATA_BYTE_WD);
    localparam logic [TOT_W-1:0] BEAT_BYTES_T = TOT_W'(DATA_BYTE_WD);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_FLUSH
    } state_t;

    state_t state;
    state_t state_next;

    // Per-packet context
    logic [CNT_W-1:0]        strip_cnt;   // S, clamped to a full beat
    logic                    first_beat;  // next accepted beat is the packet's first

    // Residual bytes carried between beats, left-justified, unused bytes zero
    logic [DATA_WD-1:0]      res_data;
    logic [CNT_W-1:0]        res_cnt;

    // Datapath for the beat currently offered on the input
    logic [CNT_W-1:0]        keep_len;
    logic [CNT_W-1:0]        contrib_cnt;
    logic [DATA_WD-1:0]      contrib_data;
    logic [TOT_W-1:0]        total_cnt;
    logic [2*DATA_WD-1:0]    merged;
    logic [DATA_WD-1:0]      merged_hi;
    logic [DATA_WD-1:0]      merged_lo;

    logic                    in_fire;
    logic                    rm_fire;
    logic                    out_fire;
    logic [CNT_W-1:0]        strip_clamped;

    // Left-justified keep vector with the first n bytes enabled.
    function automatic logic [DATA_BYTE_WD-1:0] lead_keep(input int n);
        logic [DATA_BYTE_WD-1:0] k;
        k = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            if (i < n) k[DATA_BYTE_WD-1-i] = 1'b1;
        end
        return k;
    endfunction

    // Expand byte enables to a bit mask.
    function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            m[8*i +: 8] = {8{k[i]}};
        end
        return m;
    endfunction

    // Count of enabled bytes; a non-contiguous keep is a protocol error and
    // simply contributes its popcount.
    function automatic logic [CNT_W-1:0] popcount(input logic [DATA_BYTE_WD-1:0] k);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            c = c + CNT_W'(k[i]);
        end
        return c;
    endfunction

    assign in_fire       = valid_in && ready_in;
    assign rm_fire       = valid_remove && ready_remove;
    assign out_fire      = valid_out && ready_out;
    assign strip_clamped = (byte_remove_cnt > BEAT_BYTES) ? BEAT_BYTES : byte_remove_cnt;

    // Align the incoming beat behind the residual bytes.
    always_comb begin
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        keep_len     = popcount(keep_in);
        contrib_cnt  = keep_len;
        contrib_data = data_in;
        if (first_beat) begin
            contrib_cnt  = (keep_len > strip_cnt) ? keep_len - strip_cnt : '0;
            contrib_data = data_in << (8 * int'(strip_cnt));
        end
        // Bytes past the valid count are forced to zero so they never leak out.
        contrib_data = contrib_data & byte_mask(lead_keep(int'(contrib_cnt)));
        total_cnt    = TOT_W'(res_cnt) + TOT_W'(contrib_cnt);
        merged       = {res_data, {DATA_WD{1'b0}}}
                     | ({contrib_data, {DATA_WD{1'b0}}} >> (8 * int'(res_cnt)));
    end

    assign merged_hi = merged[2*DATA_WD-1 -: DATA_WD];
    assign merged_lo = merged[DATA_WD-1:0];

    // Next-state and handshake decode.
    always_comb begin
        state_next   = state;
        ready_remove = 1'b0;
        ready_in     = 1'b0;
        case (state)
            ST_IDLE: begin
                ready_remove = 1'b1;
                if (valid_remove) state_next = ST_STREAM;
            end
            ST_STREAM: begin
                // Accept only when the output register is free or draining now.
                ready_in = !valid_out || ready_out;
                if (valid_in && ready_in && last_in) begin
                    state_next = (total_cnt > BEAT_BYTES_T) ? ST_FLUSH : ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (valid_out && ready_out && last_out) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Packet context, residual buffer and registered output beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the residual buffer is reset too, so a packet aborted by
            // reset cannot leak stale bytes into the next one.
            strip_cnt  <= '0;
            first_beat <= 1'b0;
            res_data   <= '0;
            res_cnt    <= '0;
            valid_out  <= 1'b0;
            data_out   <= '0;
            keep_out   <= '0;
            last_out   <= 1'b0;
        end else begin
            if (rm_fire) begin
                strip_cnt  <= strip_clamped;
                first_beat <= 1'b1;
                res_data   <= '0;
                res_cnt    <= '0;
            end

            if (in_fire) begin
                first_beat <= 1'b0;
                if (last_in) begin
                    if (total_cnt == '0) begin
                        // Whole packet was stripped: nothing to emit.
                        valid_out <= 1'b0;
                        res_data  <= '0;
                        res_cnt   <= '0;
                    end else if (total_cnt <= BEAT_BYTES_T) begin
                        valid_out <= 1'b1;
                        data_out  <= merged_hi;
                        keep_out  <= lead_keep(int'(total_cnt));
                        last_out  <= 1'b1;
                        res_data  <= '0;
                        res_cnt   <= '0;
                    end else begin
                        // Full beat now, the overflow bytes go out from FLUSH.
                        valid_out <= 1'b1;
                        data_out  <= merged_hi;
                        keep_out  <= '1;
                        last_out  <= 1'b0;
                        res_data  <= merged_lo;
                        res_cnt   <= CNT_W'(total_cnt - BEAT_BYTES_T);
                    end
                end else if (total_cnt >= BEAT_BYTES_T) begin
                    valid_out <= 1'b1;
                    data_out  <= merged_hi;
                    keep_out  <= '1;
                    last_out  <= 1'b0;
                    res_data  <= merged_lo;
                    res_cnt   <= CNT_W'(total_cnt - BEAT_BYTES_T);
                end else begin
                    // Not enough bytes for a beat yet; merged_lo is all zero here.
                    valid_out <= 1'b0;
                    res_data  <= merged_hi;
                    res_cnt   <= CNT_W'(total_cnt);
                end
            end else if (state == ST_FLUSH && out_fire && !last_out) begin
                // The full beat drained; present the trailing partial beat.
                valid_out <= 1'b1;
                data_out  <= res_data;
                keep_out  <= lead_keep(int'(res_cnt));
                last_out  <= 1'b1;
                res_data  <= '0;
                res_cnt   <= '0;
            end else if (out_fire) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_remove_header.sv
// Directed bench for axi_stream_remove_header with hand-computed beats.

module tb_axi_stream_remove_header;

    localparam int DW = 32;
    localparam int BW = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic [BW-1:0] keep_in;
    logic          last_in;
    logic          ready_in;
    logic          valid_remove;
    logic [CW:0]   byte_remove_cnt;
    logic          ready_remove;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic [BW-1:0] keep_out;
    logic          last_out;
    logic          ready_out;

    int total = 0;
    int bad   = 0;

    axi_stream_remove_header #(
        .DATA_WD(DW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .data_in        (data_in),
        .keep_in        (keep_in),
        .last_in        (last_in),
        .ready_in       (ready_in),
        .valid_remove   (valid_remove),
        .byte_remove_cnt(byte_remove_cnt),
        .ready_remove   (ready_remove),
        .valid_out      (valid_out),
        .data_out       (data_out),
        .keep_out       (keep_out),
        .last_out       (last_out),
        .ready_out      (ready_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are driven and registered outputs sampled 1 after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [DW-1:0] d,
                             input logic [BW-1:0] k, input logic l);
        check({tag, ".valid"}, 64'(valid_out), 64'(v));
        if (v) begin
            check({tag, ".data"}, 64'(data_out), 64'(d));
            check({tag, ".keep"}, 64'(keep_out), 64'(k));
            check({tag, ".last"}, 64'(last_out), 64'(l));
        end
    endtask

    // Combinational handshakes, sampled after the new inputs settle.
    task automatic check_ready(input string tag, input logic exp_in, input logic exp_rm);
        #1;
        check({tag, ".ready_in"}, 64'(ready_in), 64'(exp_in));
        check({tag, ".ready_remove"}, 64'(ready_remove), 64'(exp_rm));
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic [BW-1:0] k, input logic l);
        valid_in = 1'b1;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
    endtask

    task automatic idle_in();
        valid_in = 1'b0;
        data_in  = '0;
        keep_in  = '0;
        last_in  = 1'b0;
    endtask

    task automatic start_packet(input logic [CW:0] cnt);
        valid_remove    = 1'b1;
        byte_remove_cnt = cnt;
        cycle();
        valid_remove    = 1'b0;
        byte_remove_cnt = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        valid_remove    = 1'b0;
        byte_remove_cnt = '0;
        ready_out       = 1'b1;
        idle_in();

        // Reset state
        cycle();
        cycle();
        rst = 1'b0;
        check("rst.valid_out", 64'(valid_out), 64'(0));
        check("rst.data_out", 64'(data_out), 64'(0));
        check("rst.keep_out", 64'(keep_out), 64'(0));
        check("rst.last_out", 64'(last_out), 64'(0));
        check_ready("rst", 1'b0, 1'b1);

        // S=2 realignment across beats, last beat fills exactly one beat
        start_packet(3'd2);
        check_ready("a.stream", 1'b1, 1'b0);
        beat(32'hAABBCCDD, 4'hF, 1'b0);
        cycle();
        check_out("a.b1", 1'b0, '0, '0, 1'b0);
        beat(32'h11223344, 4'hF, 1'b0);
        cycle();
        check_out("a.o1", 1'b1, 32'hCCDD1122, 4'hF, 1'b0);
        beat(32'h55667788, 4'hF, 1'b0);
        cycle();
        check_out("a.o2", 1'b1, 32'h33445566, 4'hF, 1'b0);
        beat(32'hEEFF0000, 4'hC, 1'b1);
        cycle();
        check_out("a.o3", 1'b1, 32'h7788EEFF, 4'hF, 1'b1);
        idle_in();
        check_ready("a.idle", 1'b0, 1'b1);
        cycle();
        check_out("a.drain", 1'b0, '0, '0, 1'b0);

        // S=0 pass-through at full rate
        start_packet(3'd0);
        beat(32'h01234567, 4'hF, 1'b0);
        cycle();
        check_out("b.o1", 1'b1, 32'h01234567, 4'hF, 1'b0);
        beat(32'h89ABCDEF, 4'hF, 1'b0);
        check_ready("b.full_rate", 1'b1, 1'b0);
        cycle();
        check_out("b.o2", 1'b1, 32'h89ABCDEF, 4'hF, 1'b0);
        beat(32'h13570000, 4'hC, 1'b1);
        cycle();
        check_out("b.o3", 1'b1, 32'h13570000, 4'hC, 1'b1);
        idle_in();
        cycle();
        check_out("b.drain", 1'b0, '0, '0, 1'b0);

        // S=1 with a flush beat
        start_packet(3'd1);
        beat(32'hA0A1A2A3, 4'hF, 1'b0);
        cycle();
        check_out("c.b1", 1'b0, '0, '0, 1'b0);
        beat(32'hB0B1B2B3, 4'hE, 1'b1);
        cycle();
        check_out("c.o1", 1'b1, 32'hA1A2A3B0, 4'hF, 1'b0);
        idle_in();
        check_ready("c.flush1", 1'b0, 1'b0);
        cycle();
        check_out("c.o2", 1'b1, 32'hB1B20000, 4'hC, 1'b1);
        check_ready("c.flush2", 1'b0, 1'b0);
        cycle();
        check_out("c.drain", 1'b0, '0, '0, 1'b0);
        check_ready("c.idle", 1'b0, 1'b1);

        // S=4 single beat: fully stripped, no output
        start_packet(3'd4);
        beat(32'hDEADBEEF, 4'hF, 1'b1);
        cycle();
        idle_in();
        check_out("d.none", 1'b0, '0, '0, 1'b0);
        check_ready("d.idle", 1'b0, 1'b1);
        cycle();
        check_out("d.none2", 1'b0, '0, '0, 1'b0);

        // Strip count above a beat clamps to a full beat
        start_packet(3'd7);
        beat(32'h11111111, 4'hF, 1'b0);
        cycle();
        check_out("d.clamp_b1", 1'b0, '0, '0, 1'b0);
        beat(32'h9ABCDEF0, 4'hF, 1'b1);
        cycle();
        check_out("d.clamp_o1", 1'b1, 32'h9ABCDEF0, 4'hF, 1'b1);
        idle_in();
        cycle();

        // S=2 with three cycles of backpressure mid-packet
        start_packet(3'd2);
        beat(32'h01020304, 4'hF, 1'b0);
        cycle();
        check_out("e.b1", 1'b0, '0, '0, 1'b0);
        beat(32'h05060708, 4'hF, 1'b0);
        cycle();
        check_out("e.o1", 1'b1, 32'h03040506, 4'hF, 1'b0);
        ready_out = 1'b0;
        beat(32'h090A0B0C, 4'hF, 1'b0);
        check_ready("e.stall0", 1'b0, 1'b0);
        cycle();
        check_out("e.hold1", 1'b1, 32'h03040506, 4'hF, 1'b0);
        check_ready("e.stall1", 1'b0, 1'b0);
        cycle();
        check_out("e.hold2", 1'b1, 32'h03040506, 4'hF, 1'b0);
        cycle();
        check_out("e.hold3", 1'b1, 32'h03040506, 4'hF, 1'b0);
        ready_out = 1'b1;
        check_ready("e.resume", 1'b1, 1'b0);
        cycle();
        check_out("e.o2", 1'b1, 32'h0708090A, 4'hF, 1'b0);
        beat(32'h0D0E0F10, 4'hF, 1'b1);
        cycle();
        check_out("e.o3", 1'b1, 32'h0B0C0D0E, 4'hF, 1'b0);
        idle_in();
        cycle();
        check_out("e.o4", 1'b1, 32'h0F100000, 4'hC, 1'b1);
        cycle();
        check_out("e.drain", 1'b0, '0, '0, 1'b0);

        // Reset mid-packet drops residual and pending beat
        start_packet(3'd1);
        beat(32'h11223344, 4'hF, 1'b0);
        cycle();
        beat(32'h55667788, 4'hF, 1'b0);
        cycle();
        check_out("f.o1", 1'b1, 32'h22334455, 4'hF, 1'b0);
        ready_out = 1'b0;
        idle_in();
        rst = 1'b1;
        cycle();
        rst       = 1'b0;
        ready_out = 1'b1;
        check("f.rst.valid_out", 64'(valid_out), 64'(0));
        check("f.rst.data_out", 64'(data_out), 64'(0));
        check("f.rst.keep_out", 64'(keep_out), 64'(0));
        check_ready("f.rst", 1'b0, 1'b1);
        start_packet(3'd0);
        beat(32'hCAFEBABE, 4'hF, 1'b1);
        cycle();
        check_out("f.o2", 1'b1, 32'hCAFEBABE, 4'hF, 1'b1);
        idle_in();
        cycle();
        check_out("f.drain", 1'b0, '0, '0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
